// File: rtl/spi_leader_arb.sv
// Round-robin SPI leader (mode 0, LSB first) sharing one bus among NUM_REQ requesters,
// each with its own chip select. All outputs are registered.
module spi_leader_arb #(
  parameter  int NUM_REQ  = 4,
  parameter  int DATA_LEN = 8,
  parameter  int CLK_DIV  = 4,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BIT_W    = $clog2(DATA_LEN) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_data,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         rsp_valid,
  output logic [ID_W-1:0]              rsp_id,
  output logic [DATA_LEN-1:0]          rsp_data,
  output logic                         busy,
  output logic                         sclk,
  output logic                         mosi,
  input  logic                         miso,
  output logic [NUM_REQ-1:0]           cs_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [7:0]       DIV      = 8'(CLK_DIV);
  localparam logic [7:0]       DIV_M1   = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_LEN - 1);

  state_t              r_state;
  logic [7:0]          r_cnt;
  logic [BIT_W-1:0]    r_bits;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_win;
  logic [DATA_LEN-1:0] r_tx;
  logic [DATA_LEN-1:0] r_rx;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_cs_n;
  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [DATA_LEN-1:0] r_rsp_data;
  logic                r_busy;
  logic                r_sclk;
  logic                r_mosi;

  logic                w_any;
  logic [ID_W-1:0]     w_pick;
  logic [ID_W:0]       w_idx;
  logic [ID_W-1:0]     w_next_ptr;
  logic [NUM_REQ-1:0]  w_pick_oh;
  logic [DATA_LEN-1:0] w_pick_data;

  // First requesting index at or above the pointer, wrapping past NUM_REQ-1.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = {1'b0, r_ptr} + (ID_W+1)'(i);
      if (w_idx >= (ID_W+1)'(NUM_REQ)) w_idx = w_idx - (ID_W+1)'(NUM_REQ);
      if (!w_any && req[w_idx[ID_W-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == ID_W'(i)) w_pick_data = req_data[i*DATA_LEN +: DATA_LEN];
    end
    w_pick_oh  = NUM_REQ'(1) << w_pick;
    w_next_ptr = (w_pick == ID_W'(NUM_REQ - 1)) ? '0 : w_pick + 1'b1;
  end

  // NOTE: every register here is assigned with <= so all branches see the
  // pre-edge values (e.g. mosi takes r_tx[1] while r_tx itself shifts).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bits      <= '0;
      r_ptr       <= '0;
      r_win       <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_gnt       <= '0;
      r_cs_n      <= '1;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
    end else begin
      r_gnt       <= '0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_pick_oh;
            r_win   <= w_pick;
            r_ptr   <= w_next_ptr;
            r_tx    <= w_pick_data;
            r_rx    <= '0;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_state <= S_SETUP;
          end
        end
        // r_cnt enters at 0 on the first SETUP cycle, so the first rise lands CLK_DIV cycles after CS falls.
        S_SETUP: begin
          r_busy <= 1'b1;
          r_cs_n <= ~(NUM_REQ'(1) << r_win);
          r_mosi <= r_tx[0];
          if (r_cnt == DIV) begin
            r_sclk  <= 1'b1;
            r_rx    <= {miso, r_rx[DATA_LEN-1:1]};
            r_cnt   <= 8'd1;
            r_state <= S_SHIFT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_SHIFT: begin
          if (r_cnt != DIV) begin
            r_cnt <= r_cnt + 8'd1;
          end else begin
            r_cnt <= 8'd1;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
              r_rx   <= {miso, r_rx[DATA_LEN-1:1]};
            end else begin
              r_sclk <= 1'b0;
              if (r_bits == LAST_BIT) begin
                r_mosi  <= 1'b0;
                r_state <= S_HOLD;
              end else begin
                r_tx   <= r_tx >> 1;
                r_mosi <= r_tx[1];
                r_bits <= r_bits + 1'b1;
              end
            end
          end
        end
        S_HOLD: begin
          if (r_cnt == DIV) begin
            r_cs_n      <= '1;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_win;
            r_rsp_data  <= r_rx;
            r_cnt       <= 8'd1;
            r_state     <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_GAP: begin
          // Leaving one cycle early lets the IDLE grant land CLK_DIV cycles after rsp_valid.
          if (r_cnt == DIV_M1) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;
  assign sclk      = r_sclk;
  assign mosi      = r_mosi;
  assign cs_n      = r_cs_n;

  a_cs_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(~r_cs_n));
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(r_gnt));
  a_gnt_rsp_excl: assert property (@(posedge clk) disable iff (rst) !((|r_gnt) && r_rsp_valid));

endmodule

// File: tb/tb_spi_leader_arb.sv
// Self-checking bench for spi_leader_arb: vector table, hand-written corner sequences,
// and randomized transfers checked against a round-robin reference model.
module tb_spi_leader_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy, sclk, mosi, miso;
  logic [3:0]  cs_n;

  logic [3:0]  req2;
  logic [63:0] req2_data;
  logic [3:0]  gnt2;
  logic        rsp_valid2;
  logic [1:0]  rsp_id2;
  logic [15:0] rsp_data2;
  logic        busy2, sclk2, mosi2;
  logic [3:0]  cs2_n;

  spi_leader_arb #(.NUM_REQ(4), .DATA_LEN(8), .CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  // Loopback instance: miso wired straight to mosi.
  spi_leader_arb #(.NUM_REQ(4), .DATA_LEN(16), .CLK_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .req_data(req2_data), .gnt(gnt2),
    .rsp_valid(rsp_valid2), .rsp_id(rsp_id2), .rsp_data(rsp_data2), .busy(busy2),
    .sclk(sclk2), .mosi(mosi2), .miso(mosi2), .cs_n(cs2_n)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural followers: each presents its preload LSB first and captures mosi on sclk rises.
  logic [7:0] fol_tx [4];
  logic [7:0] fol_rx [4];
  int         fol_bit = 0;
  int         fol_sel;
  logic       m_sclk = 1'b0;
  logic [3:0] m_cs_n = 4'hF;
  int         cs_err = 0;
  int         gnt_cnt = 0, rsp_cnt = 0, gnt2_cnt = 0;

  always_comb begin
    fol_sel = -1;
    for (int i = 0; i < 4; i++) if (!cs_n[i]) fol_sel = i;
  end

  assign miso = (fol_sel >= 0 && fol_bit < 8) ? fol_tx[fol_sel[1:0]][fol_bit[2:0]] : 1'b0;

  always @(negedge clk) begin
    m_sclk <= sclk;
    m_cs_n <= cs_n;
    if (cs_n != m_cs_n) fol_bit <= 0;
    else if (sclk && !m_sclk) begin
      fol_bit <= fol_bit + 1;
      if (fol_sel >= 0) fol_rx[fol_sel[1:0]] <= {mosi, fol_rx[fol_sel[1:0]][7:1]};
    end
    if ($countones(~cs_n) > 1 || $countones(~cs2_n) > 1) cs_err <= cs_err + 1;
    if (|gnt) gnt_cnt <= gnt_cnt + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (|gnt2) gnt2_cnt <= gnt2_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(input bit sel2, output int idx, output int t);
    logic [3:0] g;
    idx = -1;
    t   = -1;
    g   = '0;
    for (int n = 0; n < 400 && idx < 0; n++) begin
      @(negedge clk);
      g = sel2 ? gnt2 : gnt;
      for (int i = 0; i < 4; i++) if (g[i]) idx = i;
      if (idx >= 0) t = cyc;
    end
    if (idx < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL gnt_timeout: no gnt within 400 cycles, expected one");
    end else begin
      check("gnt_onehot", $countones(g), 1);
    end
  endtask

  task automatic wait_rsp(input bit sel2, output int id, output logic [15:0] data, output int t);
    bit seen;
    seen = 1'b0;
    id   = -1;
    data = '0;
    t    = -1;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (sel2 ? rsp_valid2 : rsp_valid) begin
        seen = 1'b1;
        id   = sel2 ? int'(rsp_id2) : int'(rsp_id);
        data = sel2 ? rsp_data2 : {8'h00, rsp_data};
        t    = cyc;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL rsp_timeout: no rsp_valid within 400 cycles, expected one");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req  = '0;
    req2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  function automatic int rr_pick(input logic [3:0] mask, input int ptr);
    for (int i = 0; i < 4; i++) if (mask[(ptr + i) % 4]) return (ptr + i) % 4;
    return -1;
  endfunction

  typedef struct {
    logic [3:0] req;
    logic [7:0] tx;
    logic [7:0] fol;
    int         exp_id;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int          idx, tg, tr, rid, prev_t, g0, r0, ptr_m, exp_id, k;
    logic [15:0] rd;
    logic [7:0]  ew, exp_data;
    logic [7:0]  wtx [4];
    logic        ps;

    vecs[0] = '{4'b0001, 8'h11, 8'h3C, 0};
    vecs[1] = '{4'b1111, 8'h22, 8'h47, 1};
    vecs[2] = '{4'b0001, 8'h33, 8'h58, 0};
    vecs[3] = '{4'b1000, 8'h44, 8'h69, 3};
    vecs[4] = '{4'b0110, 8'h55, 8'h0A, 1};
    vecs[5] = '{4'b1001, 8'h66, 8'h1B, 3};
    vecs[6] = '{4'b0101, 8'h77, 8'h2C, 0};
    vecs[7] = '{4'b1100, 8'h88, 8'h3D, 2};
    vecs[8] = '{4'b0011, 8'h99, 8'h4E, 0};

    rst = 1'b1; req = '0; req_data = '0; req2 = '0; req2_data = '0;
    for (int i = 0; i < 4; i++) begin fol_tx[i] = '0; fol_rx[i] = '0; end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 4'h0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_busy", busy, 0);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_cs_n", cs_n, 4'hF);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_gnt", gnt, 4'h0);

    // Single transfer: 0xA5 out, follower 0 returns 0x3C
    fol_tx[0] = 8'h3C;
    req_data[7:0] = 8'hA5;
    ew = 8'hA5;
    req = 4'b0001;
    wait_gnt(0, idx, tg);
    req = '0;
    check("single_gnt_id", idx, 0);
    @(negedge clk);
    check("single_cs_n_T1", cs_n, 4'b1110);
    check("single_busy_T1", busy, 1);
    ps = 1'b0;
    k  = 0;
    for (int n = 0; n < 200 && k < 8; n++) begin
      @(negedge clk);
      if (sclk && !ps) begin
        check($sformatf("single_rise%0d_cycle", k), cyc - tg, 5 + 8 * k);
        check($sformatf("single_rise%0d_mosi", k), mosi, ew[k]);
        k++;
      end
      ps = sclk;
    end
    check("single_rise_count", k, 8);
    wait_rsp(0, rid, rd, tr);
    check("single_rsp_latency", tr - tg, 69);
    check("single_rsp_id", rid, 0);
    check("single_rsp_data", rd, 16'h003C);
    check("single_cs_n_released", cs_n, 4'hF);
    check("single_follower_rx", fol_rx[0], 8'hA5);
    repeat (6) @(negedge clk);
    check("single_rsp_data_held", rsp_data, 8'h3C);
    check("single_busy_after", busy, 0);

    // Vector table: arbitration from a known pointer history
    do_reset();
    foreach (vecs[v]) begin
      for (int i = 0; i < 4; i++) begin
        fol_tx[i] = vecs[v].fol + 8'(16 * i);
        req_data[i*8 +: 8] = vecs[v].tx ^ 8'(i);
      end
      req = vecs[v].req;
      wait_gnt(0, idx, tg);
      req = '0;
      check($sformatf("vec%0d_gnt", v), idx, vecs[v].exp_id);
      wait_rsp(0, rid, rd, tr);
      exp_data = vecs[v].fol + 8'(16 * vecs[v].exp_id);
      check($sformatf("vec%0d_rsp_id", v), rid, vecs[v].exp_id);
      check($sformatf("vec%0d_rsp_data", v), rd, {8'h00, exp_data});
      check($sformatf("vec%0d_latency", v), tr - tg, 69);
      check($sformatf("vec%0d_follower_rx", v), fol_rx[vecs[v].exp_id[1:0]], vecs[v].tx ^ 8'(vecs[v].exp_id));
    end

    // Contention: all four held, expect 0,1,2,3 spaced 73 cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fol_tx[i] = 8'hC0 + 8'(i);
      req_data[i*8 +: 8] = 8'h50 + 8'(i);
    end
    req = 4'b1111;
    prev_t = 0;
    for (int n = 0; n < 4; n++) begin
      wait_gnt(0, idx, tg);
      check($sformatf("cont%0d_gnt", n), idx, n);
      if (n > 0) check($sformatf("cont%0d_spacing", n), tg - prev_t, 73);
      prev_t = tg;
      if (idx >= 0) req[idx] = 1'b0;
      wait_rsp(0, rid, rd, tr);
      check($sformatf("cont%0d_rsp_id", n), rid, n);
      check($sformatf("cont%0d_rsp_data", n), rd, 16'h00C0 + 16'(n));
    end

    // Fairness: req[1] and req[2] held for six transfers
    do_reset();
    req = 4'b0110;
    for (int n = 0; n < 6; n++) begin
      wait_gnt(0, idx, tg);
      check($sformatf("fair%0d_gnt", n), idx, (n % 2 == 0) ? 1 : 2);
      if (n == 5) req = '0;
      wait_rsp(0, rid, rd, tr);
      check($sformatf("fair%0d_rsp_id", n), rid, (n % 2 == 0) ? 1 : 2);
    end

    // Reset after the 4th sclk rise
    do_reset();
    fol_tx[1] = 8'h96;
    req = 4'b0010;
    wait_gnt(0, idx, tg);
    req = '0;
    ps = 1'b0;
    k  = 0;
    for (int n = 0; n < 200 && k < 4; n++) begin
      @(negedge clk);
      if (sclk && !ps) k++;
      ps = sclk;
    end
    check("rstmid_rises_seen", k, 4);
    r0 = rsp_cnt;
    #2 rst = 1'b1;
    #1;
    check("rstmid_cs_n", cs_n, 4'hF);
    check("rstmid_sclk", sclk, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    req = 4'b1001;
    @(negedge clk);
    rst = 1'b0;
    wait_gnt(0, idx, tg);
    check("rstmid_first_gnt", idx, 0);
    req = 4'b1000;
    wait_rsp(0, rid, rd, tr);
    check("rstmid_rsp_id", rid, 0);
    @(negedge clk);
    check("rstmid_rsp_count", rsp_cnt - r0, 1);
    wait_gnt(0, idx, tg);
    check("rstmid_second_gnt", idx, 3);
    req = '0;
    wait_rsp(0, rid, rd, tr);
    check("rstmid_second_rsp_id", rid, 3);

    // Minimum divider, 16-bit loopback, withdrawn request
    do_reset();
    g0 = gnt2_cnt;
    req2_data[15:0] = 16'hBEEF;
    req2_data[47:32] = 16'h1234;
    req2 = 4'b0001;
    wait_gnt(1, idx, tg);
    req2 = '0;
    check("loop_gnt", idx, 0);
    repeat (10) @(negedge clk);
    req2 = 4'b0100;
    repeat (5) @(negedge clk);
    req2 = '0;
    wait_rsp(1, rid, rd, tr);
    check("loop_latency", tr - tg, 67);
    check("loop_rsp_data", rd, 16'hBEEF);
    check("loop_rsp_id", rid, 0);
    repeat (20) @(negedge clk);
    check("loop_withdrawn_never_granted", gnt2_cnt - g0, 1);
    check("loop_busy_after", busy2, 0);

    // Randomized transfers against the round-robin model, with req churn mid-transfer
    do_reset();
    ptr_m = 0;
    g0 = gnt_cnt;
    for (int r = 0; r < 16; r++) begin
      logic [3:0] mask;
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        fol_tx[i] = 8'($urandom);
        wtx[i]    = 8'($urandom);
        req_data[i*8 +: 8] = wtx[i];
      end
      exp_id = rr_pick(mask, ptr_m);
      ptr_m  = (exp_id + 1) % 4;
      exp_data = fol_tx[exp_id[1:0]];
      req = mask;
      wait_gnt(0, idx, tg);
      check($sformatf("rand%0d_gnt", r), idx, exp_id);
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        req = 4'($urandom);
      end
      req = '0;
      wait_rsp(0, rid, rd, tr);
      check($sformatf("rand%0d_rsp_id", r), rid, exp_id);
      check($sformatf("rand%0d_rsp_data", r), rd, {8'h00, exp_data});
      check($sformatf("rand%0d_latency", r), tr - tg, 69);
      check($sformatf("rand%0d_follower_rx", r), fol_rx[exp_id[1:0]], wtx[exp_id[1:0]]);
    end
    repeat (2) @(negedge clk);
    check("rand_gnt_total", gnt_cnt - g0, 16);

    check("cs_never_multiple_low", cs_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
